// File: rtl/edge_timer.sv
// Interval meter for a filtered, clock-synchronous level: detects edges and
// reports each completed interval's level and length in clock-enable ticks.
module edge_timer #(
  parameter int       W           = 8,
  parameter int       TIMEOUT     = 200,
  parameter bit       RESET_LEVEL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in,
  input  logic         ce,
  output logic         valid,
  output logic         level,
  output logic [W-1:0] len,
  output logic         rise,
  output logic         fall,
  output logic         idle
);

  typedef enum logic [1:0] {SYNC, RUN, IDLE} state_t;

  localparam logic [W-1:0] TMO = W'(TIMEOUT);

  state_t         state_q, state_d;
  logic           in_q, in_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           level_q, level_d;
  logic [W-1:0]   len_q, len_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic           edge_c;

  always_comb begin
    edge_c  = in ^ in_q;
    in_d    = in;
    rise_d  = in & ~in_q;
    fall_d  = ~in & in_q;
    state_d = state_q;
    valid_d = 1'b0;
    level_d = level_q;
    len_d   = len_q;
    cnt_d   = cnt_q;

    // Saturating tick counter; frozen while IDLE so a stale count is never reported.
    if (edge_c)
      cnt_d = ce ? W'(1) : '0;
    else if (state_q != IDLE && cnt_q != TMO)
      cnt_d = cnt_q + W'(ce);

    case (state_q)
      SYNC: if (edge_c) state_d = RUN;
      RUN: begin
        if (edge_c) begin
          valid_d = 1'b1;
          level_d = in_q;
          len_d   = cnt_q;
        end else if (cnt_q == TMO) begin
          state_d = IDLE;
        end
      end
      IDLE: if (edge_c) state_d = RUN;
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC;
      in_q    <= RESET_LEVEL;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      level_q <= 1'b0;
      len_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      level_q <= level_d;
      len_q   <= len_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign valid = valid_q;
  assign level = level_q;
  assign len   = len_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign idle  = (state_q == IDLE);

endmodule

// File: tb/tb_edge_timer.sv
// Directed bench for edge_timer (W=8, TIMEOUT=100, RESET_LEVEL=1).
module tb_edge_timer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in;
  logic         ce;
  logic         valid, level, rise, fall, idle;
  logic [W-1:0] len;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int cyc    = 0;
  int v0;
  bit ce_mode = 1'b0;

  edge_timer #(.W(W), .TIMEOUT(100), .RESET_LEVEL(1'b1)) dut (
    .clk(clk), .reset(reset), .in(in), .ce(ce),
    .valid(valid), .level(level), .len(len),
    .rise(rise), .fall(fall), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcnt++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    ce = ce_mode ? ((cyc % 4) == 0) : 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drive a new level and step through the edge cycle; outputs then show its result.
  task automatic edge_to(input logic v);
    in = v;
    tick();
  endtask

  task automatic chk_iv(input string tag, input int lv, input int ln);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_level"}, level, lv);
    chk({tag, "_len"}, len, ln);
  endtask

  initial begin
    reset = 1'b1;
    in    = 1'b1;
    ce    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_len", len, 0);
    chk("rst_idle", idle, 0);
    reset = 1'b0;

    // 1: first edge from SYNC is discarded, second reports the 0 interval
    ticks(20);
    chk("t1_novalid_pre", vcnt, 0);
    edge_to(1'b0);
    chk("t1_fall", fall, 1);
    chk("t1_rise0", rise, 0);
    chk("t1_novalid", valid, 0);
    tick();
    chk("t1_fall_1cyc", fall, 0);
    ticks(28);
    edge_to(1'b1);
    chk("t1_rise", rise, 1);
    chk_iv("t1", 0, 30);
    tick();
    chk("t1_valid_1cyc", valid, 0);
    chk("t1_len_held", len, 30);

    // 2: sequence of intervals
    ticks(28);
    edge_to(1'b0);
    chk_iv("t2a", 1, 30);
    ticks(6);
    edge_to(1'b1);
    chk_iv("t2b", 0, 7);
    ticks(11);
    edge_to(1'b0);
    chk_iv("t2c", 1, 12);

    // 3: timeout into IDLE, re-entry without report, then true length
    ticks(99);
    chk("t3_idle_100", idle, 0);
    v0 = vcnt;
    tick();
    chk("t3_idle_101", idle, 1);
    ticks(49);
    chk("t3_idle_150", idle, 1);
    edge_to(1'b1);
    chk("t3_exit_idle", idle, 0);
    chk("t3_exit_novalid", valid, 0);
    chk("t3_exit_rise", rise, 1);
    chk("t3_no_valid_span", vcnt, v0);
    ticks(24);
    edge_to(1'b0);
    chk_iv("t3", 1, 25);

    // 4: ce every 4th cycle, 40-cycle level -> 10 ticks
    ce_mode = 1'b1;
    ticks(5);
    edge_to(1'b1);
    ticks(39);
    edge_to(1'b0);
    chk_iv("t4", 1, 10);
    ce_mode = 1'b0;

    // 5: asynchronous reset mid-interval
    ticks(14);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", valid, 0);
    chk("t5_level", level, 0);
    chk("t5_len", len, 0);
    chk("t5_rise", rise, 0);
    chk("t5_fall", fall, 0);
    chk("t5_idle", idle, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("t5_sync_fall", fall, 1);
    chk("t5_sync_novalid", valid, 0);
    ticks(9);
    edge_to(1'b1);
    chk_iv("t5_after", 0, 10);

    // 6: edge exactly when the count reaches TIMEOUT
    ticks(99);
    chk("t6_pre_idle", idle, 0);
    edge_to(1'b0);
    chk_iv("t6", 1, 100);
    chk("t6_idle", idle, 0);

    // Minimum interval: edges on consecutive cycles
    edge_to(1'b1);
    chk_iv("min_a", 0, 1);
    edge_to(1'b0);
    chk_iv("min_b", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", cyc, 0);
    $fatal(1);
  end
endmodule
